// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and the
// transmit-queue launch FSM state encoding.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    RELAUNCH  = 2'd2,
    WAIT_DONE = 2'd3
  } txq_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Transmit-queue bus: system-side valid/ready byte stream plus the launch
// interface toward the UART top level (start/data_in/tx_busy).
// slave  = the queue's view, master = the system + UART view.
interface uart_tx_queue_if;
  import uart_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [UART_DW-1:0] s_data;
  logic               uart_start;
  logic [UART_DW-1:0] uart_data;
  logic               uart_busy;

  modport master (
    output s_valid, s_data, uart_busy,
    input  s_ready, uart_start, uart_data
  );

  modport slave (
    input  s_valid, s_data, uart_busy,
    output s_ready, uart_start, uart_data
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full flag and a registered read-data
// output that only updates on a pop. Flush clears pointers and count and
// overrides any push or pop in the same cycle. A push while full is refused
// even if a pop happens in that cycle.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_reg && !flush;
  assign do_pop  = pop && (count_reg != '0) && !flush;

  // Next occupancy: flush wins, simultaneous push+pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointers, occupancy and the registered full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
    end
  end

  // Storage array; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  // Registered read port; holds the last popped entry between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (do_pop) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  assign rd_data = rd_data_reg;
  assign full    = full_reg;
  assign empty   = (count_reg == '0);
  assign count   = count_reg;

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered UART transmit front-end. Bytes arrive on a valid/ready stream,
// are queued in uart_sync_fifo and launched one at a time into the UART with
// a one-cycle start pulse. If the UART does not raise busy within BUSY_WAIT
// cycles of a launch, the same byte is launched again.
// Optional build macro UART_TXQ_LEVEL_EN adds the level and almost_full ports.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BUSY_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_queue_if.slave    bus,
  input  logic              flush,
  output logic              idle
`ifdef UART_TXQ_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(BUSY_WAIT);

  txq_state_t         state_reg;
  txq_state_t         state_next;
  logic [WW-1:0]      cnt_reg;
  logic [WW-1:0]      cnt_next;
  logic               start_reg;
  logic               start_next;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [UART_DW-1:0] fifo_rd_data;

  // The FIFO's read register is the byte presented to the UART: it changes
  // only on a pop, so a relaunch resends exactly the same byte.
  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (bus.s_valid),
    .pop     (pop),
    .flush   (flush),
    .wr_data (bus.s_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Launch FSM next-state: pop and launch from IDLE, watch for busy, retry
  // on timeout, then wait for the UART to finish the frame.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    start_next = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((fifo_count != '0) && !flush) begin
          pop        = 1'b1;
          start_next = 1'b1;
          cnt_next   = '0;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.uart_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg == WW'(BUSY_WAIT - 1)) begin
          state_next = RELAUNCH;
        end else begin
          cnt_next = cnt_reg + WW'(1);
        end
      end
      RELAUNCH: begin
        start_next = 1'b1;
        cnt_next   = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (!bus.uart_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, wait counter and registered start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      start_reg <= start_next;
    end
  end

  assign bus.s_ready    = !fifo_full;
  assign bus.uart_start = start_reg;
  assign bus.uart_data  = fifo_rd_data;
  assign idle           = fifo_empty && (state_reg == IDLE);

`ifdef UART_TXQ_LEVEL_EN
  logic          push_eff;
  logic [CW-1:0] level_next;
  logic          almost_full_reg;

  assign push_eff = bus.s_valid && !fifo_full && !flush;

  // Occupancy after this edge, used so almost_full lines up with count.
  always_comb begin
    level_next = fifo_count;
    if (flush) begin
      level_next = '0;
    end else if (push_eff && !pop) begin
      level_next = fifo_count + CW'(1);
    end else if (pop && !push_eff) begin
      level_next = fifo_count - CW'(1);
    end
  end

  // Registered almost-full flag, two entries short of full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_reg <= 1'b0;
    end else begin
      almost_full_reg <= (level_next >= CW'(DEPTH - 2));
    end
  end

  assign level       = fifo_count;
  assign almost_full = almost_full_reg;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a small behavioural UART busy model
// and a launch monitor that logs every start pulse.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH     = 16;
  localparam int BUSY_WAIT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic idle;
`ifdef UART_TXQ_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
  logic                   almost_full;
`endif

  uart_tx_queue_if bus();

  uart_tx_queue #(
    .DEPTH     (DEPTH),
    .BUSY_WAIT (BUSY_WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .flush (flush),
    .idle  (idle)
`ifdef UART_TXQ_LEVEL_EN
    , .level(level), .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // UART busy: either driven directly, or by a model that raises busy
  // busy_delay cycles after a start and holds it busy_len cycles.
  logic auto_mode   = 1'b0;
  logic manual_busy = 1'b0;
  logic model_busy  = 1'b0;
  int   busy_delay  = 3;
  int   busy_len    = 20;
  int   dly_cnt     = 0;
  int   hold_cnt    = 0;

  assign bus.uart_busy = auto_mode ? model_busy : manual_busy;

  always @(negedge clk) begin
    if (bus.uart_start === 1'b1) begin
      dly_cnt <= busy_delay;
    end else if (dly_cnt > 0) begin
      dly_cnt <= dly_cnt - 1;
      if (dly_cnt == 1) begin
        model_busy <= 1'b1;
        hold_cnt   <= busy_len;
      end
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) model_busy <= 1'b0;
    end
  end

  logic [7:0] launch_data[$];
  int         launch_cyc[$];

  always @(negedge clk) begin
    if (bus.uart_start === 1'b1) begin
      launch_data.push_back(bus.uart_data);
      launch_cyc.push_back(cyc);
      $display("[%0d] launch data=%h", cyc, bus.uart_data);
    end
  end

  task automatic nstep(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (idle === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_log();
    launch_data.delete();
    launch_cyc.delete();
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    #1 rst_n = 1'b0;
    nstep(2);
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
    checks++; if (bus.uart_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.uart_start); end
    checks++; if (bus.uart_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.uart_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
`ifdef UART_TXQ_LEVEL_EN
    checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b want 0", almost_full); end
`endif
    rst_n = 1'b1;
    nstep(2);
    $display("[%0d] test_reset done", cyc);
  endtask

  task automatic test_single();
    bit ok;
    auto_mode = 1'b1; busy_delay = 3; busy_len = 20;
    clear_log();
    push_byte(8'hA5);
    checks++; if (bus.uart_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b want 0", bus.uart_start); end
    nstep(1);
    checks++; if (bus.uart_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", bus.uart_start); end
    checks++; if (bus.uart_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", bus.uart_data); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_launch: got %b want 0", idle); end
    nstep(1);
    checks++; if (bus.uart_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", bus.uart_start); end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.uart_busy === 1'b1) begin ok = 1'b1; break; end
      nstep(1);
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_busy_rise: got timeout want busy"); end
    nstep(2);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", idle); end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.uart_busy === 1'b0) begin ok = 1'b1; break; end
      nstep(1);
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_busy_fall: got timeout want fall"); end
    nstep(2);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_end: got %b want 1", idle); end
    checks++; if (launch_data.size() != 1) begin errors++; $display("FAIL single_launch_count: got %0d want 1", launch_data.size()); end
    $display("[%0d] test_single done", cyc);
  endtask

  task automatic test_back_to_back();
    bit ok;
    auto_mode = 1'b0; manual_busy = 1'b1;
    push_byte(8'hEE);
    nstep(3);
    clear_log();
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, bus.s_ready); end
      push_byte(8'(i));
    end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got %b want 0", bus.s_ready); end
    bus.s_valid = 1'b1; bus.s_data = 8'h10;
    nstep(3);
    bus.s_valid = 1'b0;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_full: got %b want 0", bus.s_ready); end
    busy_delay = 1; busy_len = 2; auto_mode = 1'b1;
    wait_idle(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got timeout want idle"); end
    nstep(3);
    checks++; if (launch_data.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d want 16", launch_data.size()); end
    for (int i = 0; i < 16 && i < launch_data.size(); i++) begin
      checks++; if (launch_data[i] !== 8'(i)) begin errors++; $display("FAIL b2b_order_%0d: got %h want %h", i, launch_data[i], 8'(i)); end
    end
    $display("[%0d] test_back_to_back done", cyc);
  endtask

  task automatic test_relaunch();
    bit ok;
    auto_mode = 1'b0; manual_busy = 1'b0;
    clear_log();
    push_byte(8'h3C);
    nstep(30);
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL relaunch_idle: got %b want 0", idle); end
`ifdef UART_TXQ_LEVEL_EN
    checks++; if (level !== '0) begin errors++; $display("FAIL relaunch_level: got %0d want 0", level); end
`endif
    nstep(30);
    manual_busy = 1'b1;
    nstep(3);
    manual_busy = 1'b0;
    wait_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL relaunch_finish: got timeout want idle"); end
    checks++; if (launch_data.size() != 4) begin errors++; $display("FAIL relaunch_count: got %0d want 4", launch_data.size()); end
    for (int i = 0; i < launch_data.size(); i++) begin
      checks++; if (launch_data[i] !== 8'h3C) begin errors++; $display("FAIL relaunch_data_%0d: got %h want 3c", i, launch_data[i]); end
    end
    for (int i = 1; i < launch_cyc.size(); i++) begin
      checks++; if (launch_cyc[i] - launch_cyc[i-1] != BUSY_WAIT + 1) begin
        errors++; $display("FAIL relaunch_period_%0d: got %0d want %0d", i, launch_cyc[i] - launch_cyc[i-1], BUSY_WAIT + 1);
      end
    end
    $display("[%0d] test_relaunch done", cyc);
  endtask

  task automatic test_flush();
    bit ok;
    auto_mode = 1'b1; busy_delay = 2; busy_len = 10;
    clear_log();
    push_byte(8'h11);
    for (int i = 0; i < 5; i++) push_byte(8'h21 + 8'(i));
    flush = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'h99;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.s_ready); end
    nstep(1);
    flush = 1'b0; bus.s_valid = 1'b0;
`ifdef UART_TXQ_LEVEL_EN
    checks++; if (level !== '0) begin errors++; $display("FAIL flush_level: got %0d want 0", level); end
`endif
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL flush_inflight: got %b want 0", idle); end
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_done: got timeout want idle"); end
    nstep(30);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle: got %b want 1", idle); end
    checks++; if (launch_data.size() != 1) begin errors++; $display("FAIL flush_count: got %0d want 1", launch_data.size()); end
    if (launch_data.size() > 0) begin
      checks++; if (launch_data[0] !== 8'h11) begin errors++; $display("FAIL flush_data: got %h want 11", launch_data[0]); end
    end
    $display("[%0d] test_flush done", cyc);
  endtask

  task automatic test_full_push_pop();
    bit ok;
    busy_delay = 1; busy_len = 2;
    auto_mode = 1'b0; manual_busy = 1'b1;
    push_byte(8'hE0);
    nstep(3);
    clear_log();
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL fpp_full: got %b want 0", bus.s_ready); end
`ifdef UART_TXQ_LEVEL_EN
    checks++; if (level !== 16) begin errors++; $display("FAIL fpp_level_full: got %0d want 16", level); end
`endif
    auto_mode = 1'b1;
    nstep(1);
    bus.s_valid = 1'b1; bus.s_data = 8'h55;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL fpp_ready_before: got %b want 0", bus.s_ready); end
    nstep(1);
    bus.s_valid = 1'b0;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL fpp_ready_after: got %b want 1", bus.s_ready); end
    checks++; if (bus.uart_data !== 8'h20) begin errors++; $display("FAIL fpp_pop_data: got %h want 20", bus.uart_data); end
`ifdef UART_TXQ_LEVEL_EN
    checks++; if (level !== 15) begin errors++; $display("FAIL fpp_level: got %0d want 15", level); end
`endif
    wait_idle(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fpp_drain: got timeout want idle"); end
    nstep(3);
    checks++; if (launch_data.size() != 16) begin errors++; $display("FAIL fpp_count: got %0d want 16", launch_data.size()); end
    for (int i = 0; i < 16 && i < launch_data.size(); i++) begin
      checks++; if (launch_data[i] !== 8'h20 + 8'(i)) begin errors++; $display("FAIL fpp_order_%0d: got %h want %h", i, launch_data[i], 8'h20 + 8'(i)); end
    end
    $display("[%0d] test_full_push_pop done", cyc);
  endtask

  task automatic test_reset_mid();
    auto_mode = 1'b0; manual_busy = 1'b1;
    push_byte(8'h70);
    nstep(3);
    for (int i = 0; i < 4; i++) push_byte(8'h71 + 8'(i));
    nstep(2);
    clear_log();
    checks++; if (bus.uart_data !== 8'h70) begin errors++; $display("FAIL rstmid_pre_data: got %h want 70", bus.uart_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.s_ready); end
    checks++; if (bus.uart_start !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b want 0", bus.uart_start); end
    checks++; if (bus.uart_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", bus.uart_data); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b want 1", idle); end
    @(negedge clk);
    rst_n = 1'b1; manual_busy = 1'b0;
    nstep(30);
    checks++; if (launch_data.size() != 0) begin errors++; $display("FAIL rstmid_no_launch: got %0d want 0", launch_data.size()); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle_after: got %b want 1", idle); end
    $display("[%0d] test_reset_mid done", cyc);
  endtask

`ifdef UART_TXQ_LEVEL_EN
  task automatic test_level();
    auto_mode = 1'b0; manual_busy = 1'b1;
    push_byte(8'h80);
    nstep(3);
    for (int i = 0; i < 13; i++) push_byte(8'h81 + 8'(i));
    checks++; if (level !== 13) begin errors++; $display("FAIL level_13: got %0d want 13", level); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL af_13: got %b want 0", almost_full); end
    push_byte(8'h8E);
    checks++; if (level !== 14) begin errors++; $display("FAIL level_14: got %0d want 14", level); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL af_14: got %b want 1", almost_full); end
    rst_n = 1'b0;
    nstep(1);
    rst_n = 1'b1; manual_busy = 1'b0;
    nstep(2);
    $display("[%0d] test_level done", cyc);
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_relaunch();
    test_flush();
    test_full_push_pop();
    test_reset_mid();
`ifdef UART_TXQ_LEVEL_EN
    test_level();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Buffered transmit front-end that sits directly upstream of the UART top level and drives its `start`/`data_in`/`tx_busy` transmit interface. Accepts bytes from the system side on a valid/ready stream, stores them in a FIFO, and launches them one at a time into the UART transmitter. Back-to-back bytes need no per-byte software handshaking.

## Interface
- `DEPTH`, 16: FIFO entries; a power of two, ≥ 2.
- `BUSY_WAIT`, 16: clock cycles allowed for `uart_busy` to rise after a launch before the byte is re-launched; ≥ 2.
- `clk` in 1: system clock, the same clock as the UART top level.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: system byte valid.
- `s_ready` out 1: queue can accept a byte.
- `s_data` in 8: system byte.
- `flush` in 1: synchronous queue clear.
- `uart_start` out 1: one-cycle launch pulse to the UART `start` input.
- `uart_data` out 8: byte to the UART `data_in` input.
- `uart_busy` in 1: the UART `tx_busy` output.
- `idle` out 1: FIFO empty and FSM in IDLE.

## Operation
- A push occurs when `s_valid && s_ready` at a rising edge. `s_ready = !full`, where `full` is registered.
- When full, a push is refused even if a pop happens in the same cycle. There is no overflow path.
- FSM states and transitions:
  - IDLE: if the FIFO is not empty, pop the head into `uart_data`, set `uart_start`, clear the wait counter, go to WAIT_BUSY.
  - WAIT_BUSY: if `uart_busy` is 1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches `BUSY_WAIT-1`, go to RELAUNCH.
  - RELAUNCH: pulse `uart_start` again with the unchanged `uart_data`, clear the counter, go to WAIT_BUSY. The byte is not lost and not re-popped.
  - WAIT_DONE: when `uart_busy` is 0, go to IDLE.
- `uart_start` is registered and high for exactly one cycle per launch.
- `uart_data` changes only at a pop and is otherwise held.
- Simultaneous push and pop when not full: both take effect and the count is unchanged.
- `flush`:
  - Empties the FIFO at the next edge by resetting pointers and count.
  - Takes priority over a push in the same cycle; that push is dropped, but `s_ready` still reads as it did.
  - Does not abort a byte already launched: the FSM completes WAIT_BUSY/WAIT_DONE normally.
  - A flush in IDLE in the same cycle as a pending pop suppresses the pop.
- Count width is `$clog2(DEPTH)+1`. Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- Reset: asynchronous, mid-operation included; discards the FIFO and any in-flight state.

## Timing
- Values during and after reset:
  - `s_ready` = 1, `uart_start` = 0, `uart_data` = 8'h00, `idle` = 1.
  - FSM in IDLE, count = 0.
- Push-to-launch latency: a push at edge N into an empty queue with the FSM in IDLE gives `uart_start` high during the cycle after edge N+1, i.e. 2 cycles.
- After `uart_busy` falls, the next launch is 2 cycles later: WAIT_DONE→IDLE, then IDLE→launch.
- `idle` is combinational from registered state. It is 0 during the `uart_start` cycle.
- `s_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the first pop from full.

## Configuration
- Macro: `UART_TXQ_LEVEL_EN`.
- Defined: adds `level` out, `$clog2(DEPTH)+1` bits, equal to the FIFO count. Also adds `almost_full` out, 1 bit, registered, high when count ≥ `DEPTH-2`. Both reset to 0.
- Undefined: neither port exists and the FIFO behaviour is identical.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum `txq_state_t` {IDLE, WAIT_BUSY, RELAUNCH, WAIT_DONE};
  - the byte width constant `UART_DW = 8`.
- Sub-module `uart_sync_fifo`, parameterised by `DEPTH` and width, provides:
  - push/pop/flush inputs;
  - `full`/`empty`/`count` outputs;
  - a registered read-data output.
- `uart_tx_queue` holds the FSM, the wait counter and the `uart_start`/`uart_data` registers.

## Test plan
- Reset, then push 8'hA5 with `uart_busy` responding 3 cycles after start and held for 20 cycles → one `uart_start` pulse 2 cycles after the push; `uart_data` = 8'hA5; `idle` = 1 after busy falls plus 2 cycles.
- Push 16 bytes 8'h00..8'h0F back-to-back while the UART is held busy → `s_ready` = 0 after the 16th push; the 17th `s_valid` is refused; bytes emerge in order 8'h00..8'h0F.
- `uart_busy` never rises after a launch of 8'h3C → `uart_start` re-pulses every `BUSY_WAIT+1` cycles with 8'h3C; count unchanged.
- `flush` with 5 bytes queued while byte 8'h11 is in flight → 8'h11 completes; no further `uart_start`; `idle` = 1.
- Full queue with a push and a pop in the same cycle → push refused; count goes 16→15; `s_ready` = 1 next cycle.
- Assert `rst_n` = 0 mid-WAIT_DONE with 4 bytes queued → outputs go to their reset values immediately; after release, no launch occurs without a new push.
- With `UART_TXQ_LEVEL_EN` defined: 14 pushes → `level` = 14, `almost_full` = 1.
